// File: rtl/in_spk_buffer.sv
// Double-buffered input-spike frame store: the host fills one bank while the
// control unit reads the previous sample from the other; banks swap on release.
module in_spk_buffer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              sample_ready,
  input  logic              sample_done,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t       r_state [2];
  logic [LEN_W-1:0]  r_len   [2];
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [ADDR_W-1:0] r_wr_off;
  logic              r_overflow;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem   [2][DEPTH];

  bank_state_t       w_state_nxt [2];
  logic [LEN_W-1:0]  w_len_nxt   [2];
  logic              w_s_ready;
  logic              w_sample_ready;
  logic              w_xfer;
  logic              w_off_max;
  logic              w_complete;
  logic              w_release;
  logic              w_rd_in_range;
  logic [LEN_W-1:0]  w_off_plus1;

  // Handshake and bank-role decisions depend only on registered state, so
  // s_ready never sees s_valid combinationally.
  assign w_s_ready      = (r_state[r_wr_sel] != FULL);
  assign w_sample_ready = (r_state[r_rd_sel] == FULL);
  assign w_xfer         = s_valid & w_s_ready;
  assign w_off_max      = &r_wr_off;
  assign w_complete     = w_xfer & (s_last | w_off_max);
  assign w_release      = sample_done & w_sample_ready;
  assign w_off_plus1    = {1'b0, r_wr_off} + LEN_W'(1);
  assign w_rd_in_range  = ({1'b0, rd_addr} < r_len[r_rd_sel]);

  // Per-bank next state. A release only ever hits the FULL reading bank and a
  // write only ever hits the non-FULL writing bank, so both can apply at once.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      // NOTE: defaults first so every path assigns every bit -- no latches.
      w_state_nxt[b] = r_state[b];
      w_len_nxt[b]   = r_len[b];
      if (w_release && (r_rd_sel == 1'(b))) begin
        w_state_nxt[b] = EMPTY;
        w_len_nxt[b]   = '0;
      end
      if (w_xfer && (r_wr_sel == 1'(b))) begin
        if (w_complete) begin
          w_state_nxt[b] = FULL;
          w_len_nxt[b]   = w_off_plus1;
        end else begin
          w_state_nxt[b] = FILLING;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= EMPTY;
        r_len[b]   <= '0;
      end
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_wr_off   <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= w_state_nxt[b];
        r_len[b]   <= w_len_nxt[b];
      end
      if (w_complete) begin
        r_wr_sel <= ~r_wr_sel;
        r_wr_off <= '0;
      end else if (w_xfer) begin
        r_wr_off <= r_wr_off + ADDR_W'(1);
      end
      if (w_release) begin
        r_rd_sel <= ~r_rd_sel;
      end
      if (w_xfer && w_off_max && !s_last) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // NOTE: the sample memory is deliberately not reset; len gating on the read
  // side hides stale bytes, and leaving it unreset lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_mem[r_wr_sel][r_wr_off] <= s_data;
    end
  end

  // Bytes past the sample length read as no spikes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (w_sample_ready && w_rd_in_range) begin
      r_rd_data <= r_mem[r_rd_sel][rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign s_ready      = w_s_ready;
  assign sample_ready = w_sample_ready;
  assign rd_data      = r_rd_data;
  assign overflow     = r_overflow;

endmodule

// File: doc/in_spk_buffer.md
# in_spk_buffer

Double-buffered input-spike frame store between the host interface and the SNN control unit. The host streams one sample's input spike bytes over a valid/ready handshake into one bank, while the control unit reads the previous sample from the other bank. A read address selects one 8-bit chunk (8 input neurons) per cycle. The control unit releases a bank with `sample_done`; the two banks then swap roles.

## Interface
Parameters:
- `ADDR_W`, default 9: byte address width; bank depth is 2^ADDR_W = 512 bytes.
- `DATA_W`, default 8: spike chunk width; bit i is the spike of neuron 8*addr+i.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  host byte valid.
- `s_ready`  out  1  buffer can accept a byte this cycle.
- `s_data`  in  DATA_W  host spike byte.
- `s_last`  in  1  marks the final byte of a sample; qualified by `s_valid`.
- `rd_addr`  in  ADDR_W  control-unit read address, in the reading bank.
- `rd_data`  out  DATA_W  registered read data.
- `sample_ready`  out  1  the reading bank holds a complete sample.
- `sample_done`  in  1  single-cycle pulse: the control unit has finished with the reading bank.
- `overflow`  out  1  sticky flag: a sample was truncated at 512 bytes.

## Operation
- Two banks, each 2^ADDR_W x DATA_W. Each bank has:
  - a state: EMPTY, FILLING or FULL;
  - a length register `len`, ADDR_W+1 bits, range 1..512.
- `wr_sel` points at the bank being filled; `rd_sel` points at the bank being read. Both toggle independently.
- `s_ready` = the state of bank `wr_sel` is not FULL. It is combinational from registered state.
- Host write (transfer = `s_valid & s_ready`):
  - EMPTY bank goes to FILLING on the first transfer, which writes offset 0.
  - Offset increments by 1 per transfer.
  - On a transfer with `s_last`, or on the transfer to offset 511:
    - `len` = offset+1;
    - the bank goes to FULL;
    - `wr_sel` toggles;
    - the offset clears.
  - The 512th byte without `s_last` also sets `overflow`.
  - Later bytes belong to the next sample.
- `sample_ready` = the state of bank `rd_sel` is FULL.
- Read:
  - `rd_data` <= mem[rd_sel][rd_addr] when `sample_ready` and `rd_addr < len[rd_sel]`;
  - otherwise `rd_data` <= 0.
  - Short samples therefore read as zero spikes beyond their length.
- `sample_done` while `sample_ready`: bank `rd_sel` goes to EMPTY, `len` clears, and `rd_sel` toggles. `sample_done` while not ready is ignored.
- Simultaneous events:
  - Bank completion and `sample_done` on the same cycle are both applied. They always target different banks, or the same bank in legal FULL->EMPTY / EMPTY->FILLING order across cycles.
  - When both banks are FULL, `s_ready` = 0 until a `sample_done`. `s_ready` returns to 1 on the cycle after that `sample_done`.
- Reset:
  - Both banks EMPTY, `len`=0, `wr_sel`=`rd_sel`=0, write offset 0.
  - `rd_data`=0, `overflow`=0, `sample_ready`=0.
  - `s_ready`=1 on the first cycle after reset deasserts.
  - Memory contents are not cleared; the `len` gating hides them.
  - Reset mid-sample discards partial and full samples.

## Timing
- Host write throughput: one byte per cycle when `s_ready`=1.
- Write-to-visibility: the bank completes on the edge of the last transfer. `sample_ready` rises on the next cycle when `rd_sel` points to that bank.
- Read latency: 1 cycle. `rd_addr` presented in cycle N gives `rd_data` valid in cycle N+1. This supports the control unit's 8 back-to-back reads per time step with mask 0..7.
- `sample_done` at edge N:
  - `sample_ready` reflects the other bank from cycle N+1;
  - reads in cycle N+1 already use the new `rd_sel`.
- `overflow` sets on the edge of the truncating transfer and clears only on reset.
- No combinational path from `s_valid` to `s_ready`.

## Test plan
- Reset, then 8-byte sample 0x01..0x08 with `s_last` on byte 8:
  - `sample_ready`=1 one cycle later;
  - reads of addr 0..7 return 0x01..0x08 with 1-cycle latency;
  - addr 8 returns 0x00.
- Fill bank 0 and bank 1 back-to-back:
  - `s_ready`=0 after the second `s_last`;
  - pulse `sample_done` → `s_ready`=1 next cycle and `sample_ready` stays 1 (bank 1);
  - addr 0 returns the bank 1 data.
- 513 bytes streamed with no `s_last`:
  - `overflow`=1 after byte 512 and bank 0 `len`=512;
  - byte 513 lands at offset 0 of bank 1.
- `sample_done` pulsed with `sample_ready`=0 → no state change; `rd_data` stays 0.
- Same cycle: bank 1 completes while `sample_done` releases bank 0 → next cycle `rd_sel`=1, `sample_ready`=1, `s_ready`=1.
- Reset asserted mid-fill after 3 bytes:
  - all outputs return to reset values;
  - a new 2-byte sample reads correctly with addr 2 = 0x00.
